paddle_ctrl: RTL and testbench

- Parametrised successor to the two-player paddle mover; drives N independent horizontal paddles on a fixed-y playfield.
- A shared tick divider sets the movement rate. Each paddle is either button-driven, with a speed ramp while held, or ball-tracking (auto/CPU opponent).
- Sits between the input debouncers and the renderer/collision logic; outputs are registered paddle left-edge x positions.

---
 rtl/paddle_pkg.sv | 46 ++++
 rtl/paddle_axis.sv | 130 +++++++++++++
 rtl/paddle_ctrl.sv | 91 +++++++++
 tb/tb_paddle_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared types, default constants and step/clamp arithmetic for the paddle controller.
// Helpers work in 32-bit int, wide enough that X_W-bit positions never wrap.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        L    = 2'd1,
        R    = 2'd2
    } dir_t;

    localparam int DEF_N_PADDLES  = 2;
    localparam int DEF_X_W        = 10;
    localparam int DEF_SCREEN_W   = 640;
    localparam int DEF_PADDLE_W   = 96;
    localparam int DEF_TICK_DIV   = 500000;
    localparam int DEF_SPEED_MIN  = 2;
    localparam int DEF_SPEED_MAX  = 8;
    localparam int DEF_AUTO_SPEED = 4;
    localparam int DEF_DEADBAND   = 4;

    function automatic int clamp_int(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int step_left(input int x, input int step);
        return (x < step) ? 0 : x - step;
    endfunction

    function automatic int step_right(input int x, input int step, input int xmax);
        return (x + step > xmax) ? xmax : x + step;
    endfunction

    // Pressing both buttons is treated the same as pressing none.
    function automatic dir_t decode_dir(input logic btn_l, input logic btn_r);
        if (btn_l && !btn_r) return L;
        if (btn_r && !btn_l) return R;
        return NONE;
    endfunction

endpackage

// File: rtl/paddle_axis.sv
// One paddle: manual FSM with speed ramp, or ball tracker when i_auto is set.
// State changes only on i_tick; i_recenter overrides a coincident tick.
module paddle_axis
    import paddle_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int XMAX       = DEF_SCREEN_W - DEF_PADDLE_W,
    parameter int CENTRE     = (DEF_SCREEN_W - DEF_PADDLE_W) / 2,
    parameter int PADDLE_W   = DEF_PADDLE_W,
    parameter int SPEED_MIN  = DEF_SPEED_MIN,
    parameter int SPEED_MAX  = DEF_SPEED_MAX,
    parameter int AUTO_SPEED = DEF_AUTO_SPEED,
    parameter int DEADBAND   = DEF_DEADBAND
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_tick,
    input  logic           i_recenter,
    input  logic           i_btn_l,
    input  logic           i_btn_r,
    input  logic           i_auto,
    input  logic [X_W-1:0] i_ball_x,
    output logic [X_W-1:0] o_x,
    output state_t         o_state
);

    localparam int SPEED_FIRST = (SPEED_MIN + 1 > SPEED_MAX) ? SPEED_MAX : SPEED_MIN + 1;

    logic [X_W-1:0] r_x;
    logic [X_W-1:0] r_speed;
    state_t         r_state;

    dir_t w_dir;
    int   w_target;
    int   w_d;
    int   w_auto_x;
    int   w_ramp;

    always_comb begin
        w_dir    = decode_dir(i_btn_l, i_btn_r);
        w_target = clamp_int(int'(i_ball_x) - PADDLE_W / 2, 0, XMAX);
        w_d      = w_target - int'(r_x);
        w_auto_x = int'(r_x);
        // Target lies inside [0, XMAX], so a step capped at |d| needs no wall clamp.
        if (w_d > DEADBAND) begin
            w_auto_x = int'(r_x) + ((w_d < AUTO_SPEED) ? w_d : AUTO_SPEED);
        end else if (w_d < -DEADBAND) begin
            w_auto_x = int'(r_x) - ((-w_d < AUTO_SPEED) ? -w_d : AUTO_SPEED);
        end
        w_ramp = (int'(r_speed) + 1 > SPEED_MAX) ? SPEED_MAX : int'(r_speed) + 1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x     <= X_W'(CENTRE);
            r_speed <= X_W'(SPEED_MIN);
            r_state <= IDLE;
        end else if (i_recenter) begin
            r_x     <= X_W'(CENTRE);
            r_speed <= X_W'(SPEED_MIN);
            r_state <= IDLE;
        end else if (i_tick) begin
            if (i_auto) begin
                r_x     <= X_W'(w_auto_x);
                r_speed <= X_W'(SPEED_MIN);
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        case (w_dir)
                            L: begin
                                r_state <= MOVE_L;
                                r_x     <= X_W'(step_left(int'(r_x), SPEED_MIN));
                                r_speed <= X_W'(SPEED_FIRST);
                            end
                            R: begin
                                r_state <= MOVE_R;
                                r_x     <= X_W'(step_right(int'(r_x), SPEED_MIN, XMAX));
                                r_speed <= X_W'(SPEED_FIRST);
                            end
                            default: r_speed <= X_W'(SPEED_MIN);
                        endcase
                    end
                    MOVE_L: begin
                        case (w_dir)
                            L: begin
                                r_x     <= X_W'(step_left(int'(r_x), int'(r_speed)));
                                r_speed <= X_W'(w_ramp);
                            end
                            R: begin
                                r_state <= MOVE_R;
                                r_x     <= X_W'(step_right(int'(r_x), SPEED_MIN, XMAX));
                                r_speed <= X_W'(SPEED_MIN);
                            end
                            default: begin
                                r_state <= IDLE;
                                r_speed <= X_W'(SPEED_MIN);
                            end
                        endcase
                    end
                    MOVE_R: begin
                        case (w_dir)
                            R: begin
                                r_x     <= X_W'(step_right(int'(r_x), int'(r_speed), XMAX));
                                r_speed <= X_W'(w_ramp);
                            end
                            L: begin
                                r_state <= MOVE_L;
                                r_x     <= X_W'(step_left(int'(r_x), SPEED_MIN));
                                r_speed <= X_W'(SPEED_MIN);
                            end
                            default: begin
                                r_state <= IDLE;
                                r_speed <= X_W'(SPEED_MIN);
                            end
                        endcase
                    end
                    default: begin
                        r_state <= IDLE;
                        r_speed <= X_W'(SPEED_MIN);
                    end
                endcase
            end
        end
    end

    assign o_x     = r_x;
    assign o_state = r_state;

endmodule

// File: rtl/paddle_ctrl.sv
// N-paddle controller: shared movement-tick divider, recentre, per-paddle axes and wall flags.
// dbg_state exposes each paddle's FSM state, 2 bits per paddle.
module paddle_ctrl
    import paddle_pkg::*;
#(
    parameter int N_PADDLES  = DEF_N_PADDLES,
    parameter int X_W        = DEF_X_W,
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int PADDLE_W   = DEF_PADDLE_W,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int SPEED_MIN  = DEF_SPEED_MIN,
    parameter int SPEED_MAX  = DEF_SPEED_MAX,
    parameter int AUTO_SPEED = DEF_AUTO_SPEED,
    parameter int DEADBAND   = DEF_DEADBAND
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     recenter,
    input  logic [N_PADDLES-1:0]     btn_left,
    input  logic [N_PADDLES-1:0]     btn_right,
    input  logic [N_PADDLES-1:0]     auto_mode,
    input  logic [X_W-1:0]           ball_x,
    output logic [N_PADDLES*X_W-1:0] paddle_x,
    output logic                     move_tick,
    output logic [N_PADDLES-1:0]     at_wall_l,
    output logic [N_PADDLES-1:0]     at_wall_r,
    output logic [N_PADDLES*2-1:0]   dbg_state
);

    localparam int XMAX   = SCREEN_W - PADDLE_W;
    localparam int CENTRE = XMAX / 2;
    localparam int DIV_W  = $clog2(TICK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic             w_wrap;
    logic             w_upd;

    assign w_wrap = (r_div == DIV_W'(TICK_DIV - 1));
    // Paddles step on the same edge that raises move_tick.
    assign w_upd  = enable & w_wrap & ~recenter;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (recenter) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (enable) begin
            r_div  <= w_wrap ? '0 : r_div + 1'b1;
            r_tick <= w_wrap;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign move_tick = r_tick;

    for (genvar gi = 0; gi < N_PADDLES; gi++) begin : g_axis
        state_t w_state;

        paddle_axis #(
            .X_W        (X_W),
            .XMAX       (XMAX),
            .CENTRE     (CENTRE),
            .PADDLE_W   (PADDLE_W),
            .SPEED_MIN  (SPEED_MIN),
            .SPEED_MAX  (SPEED_MAX),
            .AUTO_SPEED (AUTO_SPEED),
            .DEADBAND   (DEADBAND)
        ) u_axis (
            .i_clk      (clk),
            .i_rst_n    (reset),
            .i_tick     (w_upd),
            .i_recenter (recenter),
            .i_btn_l    (btn_left[gi]),
            .i_btn_r    (btn_right[gi]),
            .i_auto     (auto_mode[gi]),
            .i_ball_x   (ball_x),
            .o_x        (paddle_x[gi*X_W +: X_W]),
            .o_state    (w_state)
        );

        assign dbg_state[gi*2 +: 2] = w_state;
        assign at_wall_l[gi] = (paddle_x[gi*X_W +: X_W] == '0);
        assign at_wall_r[gi] = (paddle_x[gi*X_W +: X_W] == X_W'(XMAX));
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl with TICK_DIV = 4: directed table, corner sequences, random vs model.
// Valid/ready does not apply here; inputs change 1 ns after each rising edge and outputs are sampled there.
module tb_paddle_ctrl;
    import paddle_pkg::*;

    localparam int NP     = 2;
    localparam int XW     = 10;
    localparam int C_XMAX = 544;
    localparam int C_CTR  = 272;
    localparam int C_MIN  = 2;
    localparam int C_MAX  = 8;
    localparam int C_AUTO = 4;
    localparam int C_DB   = 4;
    localparam int C_HALF = 48;
    localparam int C_DIV  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b1;
    logic             recenter = 1'b0;
    logic [NP-1:0]    btn_left = '0;
    logic [NP-1:0]    btn_right = '0;
    logic [NP-1:0]    auto_mode = '0;
    logic [XW-1:0]    ball_x = '0;
    logic [NP*XW-1:0] paddle_x;
    logic             move_tick;
    logic [NP-1:0]    at_wall_l;
    logic [NP-1:0]    at_wall_r;
    logic [NP*2-1:0]  dbg_state;

    paddle_ctrl #(.TICK_DIV(C_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .recenter  (recenter),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .auto_mode (auto_mode),
        .ball_x    (ball_x),
        .paddle_x  (paddle_x),
        .move_tick (move_tick),
        .at_wall_l (at_wall_l),
        .at_wall_r (at_wall_r),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: positions, current held direction (0 none, 1 left, 2 right), speed, enabled-cycle count.
    int m_x[NP];
    int m_dir[NP];
    int m_spd[NP];
    int m_en;
    int m_tick;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int x_of(input int i);
        return int'(paddle_x[i*XW +: XW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_x[i] = C_CTR;
            m_dir[i] = 0;
            m_spd[i] = C_MIN;
        end
        m_en = 0;
        m_tick = 0;
    endtask

    task automatic model_move(input int i, input int dir, input int amount);
        if (dir == 1) m_x[i] = (m_x[i] - amount < 0) ? 0 : m_x[i] - amount;
        else m_x[i] = (m_x[i] + amount > C_XMAX) ? C_XMAX : m_x[i] + amount;
    endtask

    task automatic model_paddle(input int i);
        int req;
        int tgt;
        int d;
        if (auto_mode[i]) begin
            m_dir[i] = 0;
            m_spd[i] = C_MIN;
            tgt = int'(ball_x) - C_HALF;
            if (tgt < 0) tgt = 0;
            if (tgt > C_XMAX) tgt = C_XMAX;
            d = tgt - m_x[i];
            if (d > C_DB) m_x[i] += (d < C_AUTO) ? d : C_AUTO;
            else if (d < -C_DB) m_x[i] -= (-d < C_AUTO) ? -d : C_AUTO;
        end else begin
            req = (btn_left[i] && !btn_right[i]) ? 1 : ((btn_right[i] && !btn_left[i]) ? 2 : 0);
            if (req == 0) begin
                m_dir[i] = 0;
                m_spd[i] = C_MIN;
            end else if (req == m_dir[i]) begin
                model_move(i, req, m_spd[i]);
                m_spd[i] = (m_spd[i] + 1 > C_MAX) ? C_MAX : m_spd[i] + 1;
            end else begin
                model_move(i, req, C_MIN);
                m_spd[i] = (m_dir[i] == 0) ? C_MIN + 1 : C_MIN;
                m_dir[i] = req;
            end
        end
    endtask

    task automatic model_edge();
        if (recenter) begin
            model_reset();
        end else if (enable) begin
            m_en++;
            m_tick = ((m_en % C_DIV) == 0) ? 1 : 0;
            if (m_tick == 1) begin
                for (int i = 0; i < NP; i++) model_paddle(i);
            end
        end else begin
            m_tick = 0;
        end
    endtask

    task automatic compare_all();
        int exp_walls;
        exp_walls = 0;
        for (int i = 0; i < NP; i++) begin
            if (m_x[i] == 0) exp_walls |= (1 << i);
            if (m_x[i] == C_XMAX) exp_walls |= (1 << (i + NP));
        end
        check("x0", x_of(0), m_x[0]);
        check("x1", x_of(1), m_x[1]);
        check("move_tick", int'(move_tick), m_tick);
        check("walls", int'({at_wall_r, at_wall_l}), exp_walls);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_x0", x_of(0), C_CTR);
        check("rst_x1", x_of(1), C_CTR);
        check("rst_tick", int'(move_tick), 0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [NP-1:0] bl;
        logic [NP-1:0] br;
        int            x0;
        int            x1;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int max_x1;
        int ticks_seen;
        int held_x1;
        int exp_wait;
        int k;

        tbl[0] = '{bl: 2'b01, br: 2'b00, x0: 270, x1: 272};
        tbl[1] = '{bl: 2'b01, br: 2'b00, x0: 267, x1: 272};
        tbl[2] = '{bl: 2'b01, br: 2'b00, x0: 263, x1: 272};
        tbl[3] = '{bl: 2'b01, br: 2'b00, x0: 258, x1: 272};
        tbl[4] = '{bl: 2'b01, br: 2'b00, x0: 252, x1: 272};
        tbl[5] = '{bl: 2'b00, br: 2'b00, x0: 252, x1: 272};
        tbl[6] = '{bl: 2'b01, br: 2'b00, x0: 250, x1: 272};
        tbl[7] = '{bl: 2'b00, br: 2'b01, x0: 252, x1: 272};
        tbl[8] = '{bl: 2'b00, br: 2'b01, x0: 254, x1: 272};
        tbl[9] = '{bl: 2'b00, br: 2'b01, x0: 257, x1: 272};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_x0", x_of(0), C_CTR);
        check("rst_x1", x_of(1), C_CTR);
        check("rst_tick", int'(move_tick), 0);
        check("rst_walls", int'({at_wall_r, at_wall_l}), 0);
        check("rst_state", int'(dbg_state), int'({IDLE, IDLE}));
        @(negedge clk);
        reset = 1'b1;

        // Tick cadence and manual ramp table: one movement tick per row.
        for (int r = 0; r < 10; r++) begin
            btn_left = tbl[r].bl;
            btn_right = tbl[r].br;
            repeat (C_DIV) step();
            check($sformatf("tbl%0d_x0", r), x_of(0), tbl[r].x0);
            check($sformatf("tbl%0d_x1", r), x_of(1), tbl[r].x1);
            check($sformatf("tbl%0d_tick", r), int'(move_tick), 1);
            if (r == 4) check("state0_move_l", int'(dbg_state[1:0]), int'(MOVE_L));
        end

        // Saturation at both walls.
        btn_left = '0;
        btn_right = '0;
        do_reset();
        btn_left = 2'b01;
        btn_right = 2'b10;
        max_x1 = 0;
        repeat (60 * C_DIV) begin
            step();
            if (x_of(1) > max_x1) max_x1 = x_of(1);
        end
        check("x1_max", max_x1, C_XMAX);
        check("x1_sat", x_of(1), C_XMAX);
        check("wall_r1", int'(at_wall_r[1]), 1);
        check("x0_sat", x_of(0), 0);
        check("wall_l0", int'(at_wall_l[0]), 1);
        btn_left = 2'b11;
        btn_right = 2'b11;
        repeat (C_DIV) step();
        check("both_x0", x_of(0), 0);
        check("both_x1", x_of(1), C_XMAX);
        btn_left = 2'b10;
        btn_right = 2'b01;
        repeat (C_DIV) step();
        check("speed_min_x0", x_of(0), 2);
        check("speed_min_x1", x_of(1), C_XMAX - 2);

        // Auto tracking with deadband, then a target clamped to 0.
        btn_left = '0;
        btn_right = '0;
        do_reset();
        auto_mode = 2'b01;
        btn_left = 2'b01;
        ball_x = 10'd100;
        repeat (60 * C_DIV) step();
        check("auto_x0_52", x_of(0), 56);
        check("auto_x1", x_of(1), C_CTR);
        ball_x = 10'd40;
        repeat (20 * C_DIV) step();
        check("auto_x0_0", x_of(0), 4);
        auto_mode = '0;
        btn_left = '0;

        // Enable freeze and tick phase on re-enable.
        do_reset();
        btn_left = 2'b10;
        repeat (6) step();
        enable = 1'b0;
        held_x1 = m_x[1];
        ticks_seen = 0;
        repeat (20) begin
            step();
            if (move_tick) ticks_seen++;
        end
        check("frozen_ticks", ticks_seen, 0);
        check("frozen_x1", x_of(1), held_x1);
        enable = 1'b1;
        exp_wait = C_DIV - (m_en % C_DIV);
        k = 1;
        while (k <= 10) begin
            step();
            if (move_tick) break;
            k++;
        end
        check("reenable_wait", k, exp_wait);

        // Recenter coincident with a tick.
        k = 0;
        while ((m_en % C_DIV) != C_DIV - 1 && k < 8) begin
            step();
            k++;
        end
        recenter = 1'b1;
        step();
        check("rc_x1", x_of(1), C_CTR);
        check("rc_tick", int'(move_tick), 0);
        recenter = 1'b0;

        // Asynchronous reset mid-ramp.
        btn_left = 2'b01;
        repeat (5 * C_DIV) step();
        #2;
        reset = 1'b0;
        #1;
        check("arst_x0", x_of(0), C_CTR);
        check("arst_x1", x_of(1), C_CTR);
        check("arst_tick", int'(move_tick), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (C_DIV) step();
        check("arst_first_step", x_of(0), C_CTR - C_MIN);

        // Randomised traffic against the model.
        btn_left = '0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                btn_left = NP'($urandom_range(0, 3));
                btn_right = NP'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 63) == 0) auto_mode = NP'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) ball_x = XW'($urandom_range(0, 639));
            enable = ($urandom_range(0, 9) != 0);
            recenter = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
